tlb_op_ctrl: RTL
================

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have parameter TLB_NUM, default 16, the number of TLB entries; IW = $clog2(TLB_NUM).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port op_valid  in  1  TLB instruction request.
REQ-005 SHALL have port op_code  in  2  instruction: 00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR.
REQ-006 SHALL have port op_ready  out  1  controller can accept a request.
REQ-007 SHALL have port op_done  out  1  one-cycle completion pulse.
REQ-008 SHALL have port cp0_entryhi  in  27  {vpn2[18:0], asid[7:0]}.
REQ-009 SHALL have port cp0_entrylo0  in  26  {pfn[19:0], c[2:0], d, v, g}.
REQ-010 SHALL have port cp0_entrylo1  in  26  same packing as cp0_entrylo0.
REQ-011 SHALL have port cp0_index  in  IW  Index register value.
REQ-012 SHALL have port wb_en  out  1  CP0 write-back strobe.
REQ-013 SHALL have port wb_entryhi  out  27, wb_entrylo0  out  26, wb_entrylo1  out  26: TLBR results.
REQ-014 SHALL have port wb_probe_miss  out  1, and wb_index  out  IW: TLBP results.
REQ-015 SHALL have TLB ports s_vpn2 out 19, s_odd_page out 1, s_asid out 8, s_found in 1, s_index in IW.
REQ-016 SHALL have TLB ports r_index out IW, and r_data in 78 = {vpn2 19, asid 8, g, pfn0 20, c0 3, d0, v0, pfn1 20, c1 3, d1, v1}.
REQ-017 SHALL have TLB ports we out 1, w_index out IW, and w_data out 78, packed as r_data.

Function
REQ-018 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; op_ready = 1 only in IDLE.
REQ-019 SHALL accept a request when op_valid & op_ready, and latch op_code, cp0_entryhi, both entrylo values and cp0_index; inputs outside the accept cycle are ignored.
REQ-020 SHALL, in EXEC, drive s_vpn2/s_asid from the latched entryhi and s_odd_page = 0, and register s_found/s_index for TLBP.
REQ-021 SHALL, in EXEC for TLBR, drive r_index = latched index and register r_data.
REQ-022 SHALL, in EXEC for TLBWI, assert we for exactly that cycle with w_index = latched index; w_data g = lo0.g & lo1.g, all other fields taken directly from the latches.
REQ-023 SHALL, in DONE, pulse op_done; wb_en pulses with it for TLBP and TLBR only.
REQ-024 SHALL, on a TLBP hit, produce wb_probe_miss = 0 and wb_index = s_index; on a miss, wb_probe_miss = 1 and wb_index = latched cp0_index.
REQ-025 SHALL, for TLBR, produce wb_entryhi = {vpn2, asid} and wb_entrylo0/1 = {pfnN, cN, dN, vN, g}, with g copied to both.
REQ-026 SHALL give a latency of 2 cycles: accepted at cycle N, TLB access at N+1, op_done at N+2; the next accept is at N+3 at the earliest.
REQ-027 SHALL hold we, wb_en and op_done at 0 outside the cycles named above; s_*, r_index, w_* and wb_* SHALL hold their values when idle.

Reset
REQ-028 SHALL, while resetn = 0, immediately force state IDLE, op_ready = 1, and op_done = wb_en = we = 0; all latches, wb_* and w_* SHALL be 0.
REQ-029 SHALL discard an operation interrupted by reset mid-operation, with no write and no done pulse.

Configuration
REQ-030 SHALL, when TLB_RANDOM_EN is defined, add port rand_index out IW and a Random counter.
REQ-031 SHALL reset the Random counter to TLB_NUM-1 and decrement it every cycle, wrapping from 0 to TLB_NUM-1.
REQ-032 SHALL execute TLBWR as TLBWI but with w_index equal to the Random value in the EXEC cycle.
REQ-033 SHALL, when TLB_RANDOM_EN is not defined, omit rand_index, and SHALL complete TLBWR with op_done timing unchanged, no we and no wb_en.

Verification
REQ-034 SHALL cover: TLBP, entryhi {vpn2=0x12345, asid=0x07}, s_found=1, s_index=5 -> op_done at N+2, wb_en=1, wb_probe_miss=0, wb_index=5.
REQ-035 SHALL cover: TLBP with s_found=0, cp0_index=3 -> wb_probe_miss=1, wb_index=3.
REQ-036 SHALL cover: TLBWI, index=9, lo0.g=1, lo1.g=0 -> we=1 for one cycle at N+1, w_index=9, w_data g=0, wb_en=0.
REQ-037 SHALL cover: TLBR, index=2, r_data g=1 -> wb_entrylo0.g = wb_entrylo1.g = 1, and op_ready=0 at N+1 and N+2.
REQ-038 SHALL cover: resetn low during EXEC of a TLBWI -> we drops immediately, no op_done, op_ready=1.
REQ-039 SHALL cover, with TLB_RANDOM_EN: TLBWR accepted 3 cycles after reset release with TLB_NUM=16 -> w_index=11.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// ---------------------------------------------------------------------------
// tlb_op_ctrl
//
// Purpose:
//   Sequences the four MIPS TLB instructions (TLBP, TLBR, TLBWI, TLBWR)
//   against a TLB that offers a combinational search port, a combinational
//   read port and a synchronous write port. Each request goes through
//   IDLE -> EXEC -> DONE -> IDLE. The TLB is accessed in EXEC, and the
//   op_done pulse comes in DONE.
//
// Optional feature:
//   TLB_RANDOM_EN : adds the CP0 Random counter and its rand_index output,
//                   and makes TLBWR write at the Random index. Without it,
//                   TLBWR completes with normal done timing. It does not
//                   write and does not write back.
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   op_valid/op_code         request handshake and instruction
//   op_ready/op_done         accept indication, one-cycle completion pulse
//   cp0_entryhi/lo0/lo1      CP0 EntryHi / EntryLo0 / EntryLo1 values
//   cp0_index                CP0 Index value
//   wb_en, wb_*              write-back of TLBR / TLBP results to CP0
//   s_vpn2/s_odd_page/s_asid search request; s_found/s_index search result
//   r_index/r_data           read port
//   we/w_index/w_data        write port
//   rand_index               current Random value (TLB_RANDOM_EN only)
// ---------------------------------------------------------------------------
module tlb_op_ctrl #(
  parameter  int TLB_NUM = 16,
  localparam int IW      = $clog2(TLB_NUM)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          op_valid,
  input  logic [1:0]    op_code,
  output logic          op_ready,
  output logic          op_done,
  input  logic [26:0]   cp0_entryhi,
  input  logic [25:0]   cp0_entrylo0,
  input  logic [25:0]   cp0_entrylo1,
  input  logic [IW-1:0] cp0_index,
  output logic          wb_en,
  output logic [26:0]   wb_entryhi,
  output logic [25:0]   wb_entrylo0,
  output logic [25:0]   wb_entrylo1,
  output logic          wb_probe_miss,
  output logic [IW-1:0] wb_index,
  output logic [18:0]   s_vpn2,
  output logic          s_odd_page,
  output logic [7:0]    s_asid,
  input  logic          s_found,
  input  logic [IW-1:0] s_index,
  output logic [IW-1:0] r_index,
  input  logic [77:0]   r_data,
`ifdef TLB_RANDOM_EN
  output logic [IW-1:0] rand_index,
`endif
  output logic          we,
  output logic [IW-1:0] w_index,
  output logic [77:0]   w_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
`ifdef TLB_RANDOM_EN
  localparam logic [1:0] OP_TLBWR = 2'b11;
`endif

  logic [1:0]    r_state;
  logic [1:0]    r_op;
  logic [26:0]   r_hi;
  logic [25:0]   r_lo0;
  logic [25:0]   r_lo1;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_wIdx;

  logic          w_accept;
  logic          w_curWrite;
  logic [IW-1:0] w_wrIdx;

  assign w_accept = op_valid & (r_state == S_IDLE);

`ifdef TLB_RANDOM_EN
  logic [IW-1:0] r_rand;
  logic [IW-1:0] w_randNext;

  // Random counts down every cycle and wraps from 0 to TLB_NUM-1.
  assign w_randNext = (r_rand == '0) ? IW'(TLB_NUM - 1) : (r_rand - 1'b1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rand <= IW'(TLB_NUM - 1);
    else         r_rand <= w_randNext;
  end

  assign rand_index = r_rand;

  // The EXEC cycle follows the accept edge, so its Random value is the
  // decremented value seen at accept time.
  assign w_wrIdx    = (op_code == OP_TLBWR) ? w_randNext : cp0_index;
  assign w_curWrite = (r_op == OP_TLBWI) | (r_op == OP_TLBWR);
`else
  assign w_wrIdx    = cp0_index;
  assign w_curWrite = (r_op == OP_TLBWI);
`endif

  // Three-state sequencer. A reset aborts any operation, so an interrupted
  // write or done pulse never happens.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (op_valid) r_state <= S_EXEC;
        S_EXEC:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request latches. They are only written on the accept cycle, so the TLB
  // port values derived from them hold while the controller is idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op   <= '0;
      r_hi   <= '0;
      r_lo0  <= '0;
      r_lo1  <= '0;
      r_idx  <= '0;
      r_wIdx <= '0;
    end else if (w_accept) begin
      r_op   <= op_code;
      r_hi   <= cp0_entryhi;
      r_lo0  <= cp0_entrylo0;
      r_lo1  <= cp0_entrylo1;
      r_idx  <= cp0_index;
      r_wIdx <= w_wrIdx;
    end
  end

  // Capture the search or read result at the end of EXEC. It becomes the
  // write-back data presented during DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_entryhi    <= '0;
      wb_entrylo0   <= '0;
      wb_entrylo1   <= '0;
      wb_probe_miss <= 1'b0;
      wb_index      <= '0;
    end else if (r_state == S_EXEC) begin
      if (r_op == OP_TLBP) begin
        wb_probe_miss <= ~s_found;
        wb_index      <= s_found ? s_index : r_idx;
      end
      if (r_op == OP_TLBR) begin
        wb_entryhi  <= r_data[77:51];
        wb_entrylo0 <= {r_data[49:25], r_data[50]};
        wb_entrylo1 <= {r_data[24:0],  r_data[50]};
      end
    end
  end

  assign op_ready   = (r_state == S_IDLE);
  assign op_done    = (r_state == S_DONE);
  assign wb_en      = (r_state == S_DONE) & ((r_op == OP_TLBP) | (r_op == OP_TLBR));
  assign we         = (r_state == S_EXEC) & w_curWrite;

  assign s_vpn2     = r_hi[26:8];
  assign s_asid     = r_hi[7:0];
  assign s_odd_page = 1'b0;
  assign r_index    = r_idx;

  // A TLB entry is global only if both halves say so. The EntryLo fields
  // above the G bit map directly onto the per-page entry fields.
  assign w_index    = r_wIdx;
  assign w_data     = {r_hi, r_lo0[0] & r_lo1[0], r_lo0[25:1], r_lo1[25:1]};

endmodule
